hazard_scheduler: RTL

HAZARD_SCHEDULER -- requirements
Module: hazard_scheduler

---
 rtl/hazard_scheduler.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scheduler.sv
// Hazard scheduler for a five-stage MIPS-style pipeline.
// Tracks the destination/tnew records of the instructions in E, M and W,
// decides when the D-stage instruction must stall, selects the forwarding
// source for each D operand, and models the multi-cycle HI/LO unit.
module hazard_scheduler (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] d_rs_addr,
   input  logic [4:0] d_rt_addr,
   input  logic       d_rs_used,
   input  logic       d_rt_used,
   input  logic [1:0] d_rs_tuse,
   input  logic [1:0] d_rt_tuse,
   input  logic [4:0] d_dst_addr,
   input  logic [1:0] d_tnew,
   input  logic       d_md_start,
   input  logic       d_md_div,
   input  logic       d_md_use,
   input  logic       flush,
   output logic       stall,
   output logic [1:0] fwd_rs_sel,
   output logic [1:0] fwd_rt_sel,
   output logic       md_busy
);

   // Forwarding source codes seen by the D-stage operand muxes.
   localparam logic [1:0] SEL_GRF = 2'd0;
   localparam logic [1:0] SEL_E   = 2'd1;
   localparam logic [1:0] SEL_M   = 2'd2;
   localparam logic [1:0] SEL_W   = 2'd3;

   // Latency of the HI/LO unit, counted from the edge the op leaves D.
   localparam logic [3:0] MD_MULT_CYC = 4'd5;
   localparam logic [3:0] MD_DIV_CYC  = 4'd10;

   // Pipeline records: destination register and cycles until result exists.
   logic [4:0] e_dst_q, e_dst_d;
   logic [1:0] e_tnew_q, e_tnew_d;
   logic [4:0] m_dst_q, m_dst_d;
   logic [1:0] m_tnew_q, m_tnew_d;
   logic [4:0] w_dst_q, w_dst_d;
   logic [1:0] w_tnew_q, w_tnew_d;

   // Remaining cycles of the HI/LO operation in progress.
   logic [3:0] md_cnt_q, md_cnt_d;

   // Per-source resolution results: {needs_stall, forward_select}.
   logic [2:0] rs_res;
   logic [2:0] rt_res;
   logic       md_stall;

   // Saturating decrement: a result that already exists stays at zero.
   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   // True when an in-flight record writes the register this source reads.
   // Register 0 is hardwired, so it can never be a dependency.
   function automatic logic src_hit(input logic [4:0] addr,
                                    input logic       used,
                                    input logic [4:0] dst);
      return used && (addr != 5'd0) && (addr == dst);
   endfunction

   // Resolve one D operand against E, M, W with nearest-stage priority.
   // The youngest producer holds the architecturally correct value, so the
   // first hit found decides both the stall and the forwarding source.
   function automatic logic [2:0] resolve(input logic [4:0] addr,
                                          input logic       used,
                                          input logic [1:0] tuse,
                                          input logic [4:0] e_dst,
                                          input logic [1:0] e_tnew,
                                          input logic [4:0] m_dst,
                                          input logic [1:0] m_tnew,
                                          input logic [4:0] w_dst,
                                          input logic [1:0] w_tnew);
      logic       stl;
      logic [1:0] sel;
      stl = 1'b0;
      sel = SEL_GRF;
      if (src_hit(addr, used, e_dst)) begin
         stl = (e_tnew > tuse);
         sel = (e_tnew == 2'd0) ? SEL_E : SEL_GRF;
      end else if (src_hit(addr, used, m_dst)) begin
         stl = (m_tnew > tuse);
         sel = (m_tnew == 2'd0) ? SEL_M : SEL_GRF;
      end else if (src_hit(addr, used, w_dst)) begin
         stl = (w_tnew > tuse);
         sel = (w_tnew == 2'd0) ? SEL_W : SEL_GRF;
      end
      return {stl, sel};
   endfunction

   // Combinational hazard decision from the current records and D operands.
   always_comb begin
      rs_res = resolve(d_rs_addr, d_rs_used, d_rs_tuse,
                       e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
      rt_res = resolve(d_rt_addr, d_rt_used, d_rt_tuse,
                       e_dst_q, e_tnew_q, m_dst_q, m_tnew_q, w_dst_q, w_tnew_q);
      // A new mult/div also waits: the unit holds only one operation.
      md_stall   = (d_md_use | d_md_start) & md_busy;
      stall      = rs_res[2] | rt_res[2] | md_stall;
      fwd_rs_sel = rs_res[1:0];
      fwd_rt_sel = rt_res[1:0];
   end

   assign md_busy = (md_cnt_q != 4'd0);

   // Next-state of the records: E takes D or a bubble, M and W always shift.
   always_comb begin
      if (flush || stall) begin
         e_dst_d  = 5'd0;
         e_tnew_d = 2'd0;
      end else begin
         e_dst_d  = d_dst_addr;
         e_tnew_d = d_tnew;
      end
      m_dst_d  = e_dst_q;
      m_tnew_d = tnew_dec(e_tnew_q);
      w_dst_d  = m_dst_q;
      w_tnew_d = tnew_dec(m_tnew_q);
   end

   // Next-state of the HI/LO countdown; flush deliberately leaves it alone
   // because an issued multiply/divide always runs to completion.
   always_comb begin
      if (!stall && d_md_start) begin
         md_cnt_d = d_md_div ? MD_DIV_CYC : MD_MULT_CYC;
      end else if (md_cnt_q != 4'd0) begin
         md_cnt_d = md_cnt_q - 4'd1;
      end else begin
         md_cnt_d = 4'd0;
      end
   end

   // Pipeline record registers, cleared by the active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         e_dst_q  <= 5'd0;
         e_tnew_q <= 2'd0;
         m_dst_q  <= 5'd0;
         m_tnew_q <= 2'd0;
         w_dst_q  <= 5'd0;
         w_tnew_q <= 2'd0;
      end else begin
         e_dst_q  <= e_dst_d;
         e_tnew_q <= e_tnew_d;
         m_dst_q  <= m_dst_d;
         m_tnew_q <= m_tnew_d;
         w_dst_q  <= w_dst_d;
         w_tnew_q <= w_tnew_d;
      end
   end

   // HI/LO busy counter; reset aborts any operation in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         md_cnt_q <= 4'd0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end

endmodule
